holy_axil_master: RTL

AXI-Lite initiator that turns a simple single-beat valid/ready request from a core-side client into one AXI-Lite read or write transaction. It is the master end of the bus whose slave side the PLIC and other peripherals implement, and it is used by the core's MMIO path and by the bench to drive peripheral slaves. One transaction is in flight at a time. All AXI outputs are registered.

---
 rtl/holy_axil_pkg.sv | 26 ++
 rtl/holy_axil_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/holy_axil_pkg.sv
// Shared types and constants for the holy_axil_master AXI-Lite initiator:
// FSM state encoding, AXI response codes and default bus widths.
package holy_axil_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StWaitB = 3'd2,
        StRead  = 3'd3,
        StWaitR = 3'd4,
        StResp  = 3'd5
    } axil_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/holy_axil_master.sv
// Single-outstanding AXI-Lite initiator turning a valid/ready client request into one
// read or write transaction. Optional debug counters under `HOLY_AXIL_STATS_EN.
module holy_axil_master
    import holy_axil_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
`ifdef HOLY_AXIL_STATS_EN
    ,
    output logic [2:0]            dbg_state,
    output logic [15:0]           dbg_wr_cnt,
    output logic [15:0]           dbg_rd_cnt,
    output logic [15:0]           dbg_err_cnt
`endif
);

    axil_state_e state_q, state_d;

    logic req_ready_q, req_ready_d;
    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic arvalid_q, arvalid_d;
    logic bready_q, bready_d;
    logic rready_q, rready_d;
    logic aw_done_q, aw_done_d;
    logic w_done_q, w_done_d;
    logic err_q, err_d;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic req_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;

    assign req_fire = req_valid && req_ready_q;
    assign aw_fire  = awvalid_q && m_axi_awready;
    assign w_fire   = wvalid_q && m_axi_wready;
    assign b_fire   = bready_q && m_axi_bvalid;
    assign ar_fire  = arvalid_q && m_axi_arready;
    assign r_fire   = rready_q && m_axi_rvalid;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        req_ready_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWrite;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRead;
                    end
                end
            end
            StWrite: begin
                // AW and W complete independently, in any order.
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = StWaitB;
                end
            end
            StWaitB: begin
                if (b_fire) begin
                    bready_d = 1'b0;
                    rdata_d  = '0;
                    err_d    = resp_is_err(m_axi_bresp);
                    state_d  = StResp;
                end
            end
            StRead: begin
                if (ar_fire) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StWaitR;
                end
            end
            StWaitR: begin
                if (r_fire) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axi_rdata;
                    err_d    = resp_is_err(m_axi_rresp);
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so ready rises one cycle after reset release or response retirement.
        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = (state_q == StResp);
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

`ifdef HOLY_AXIL_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        if (b_fire && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (r_fire && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (((b_fire && resp_is_err(m_axi_bresp)) || (r_fire && resp_is_err(m_axi_rresp)))
            && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign dbg_state   = state_q;
    assign dbg_wr_cnt  = wr_cnt_q;
    assign dbg_rd_cnt  = rd_cnt_q;
    assign dbg_err_cnt = err_cnt_q;
`endif

endmodule
